// File: rtl/stream_trojan_slice.sv
`timescale 1ns/1ps
// ---------------------------------------------------------------------------
// stream_trojan_slice
//
// Purpose: a 2-entry valid/ready skid buffer with an optional hidden
// trigger. When the trigger logic is compiled in, TRIG_CNT consecutive
// accepted beats equal to TRIG_VAL arm it. The beat that completes the
// match is still forwarded. The next DROP_LEN accepted beats are then
// swallowed without ever reaching the buffer.
//
// Configuration macro: STREAM_TROJAN_SLICE_EN
//   defined   -> trigger FSM, counters and drop behaviour present
//   undefined -> plain 2-entry skid buffer; trig_o tied low
//
// Ports:
//   clk     in   rising-edge clock for all state
//   rst     in   synchronous active-high reset (beats flush and traffic)
//   flush   in   synchronous clear of buffer and trigger state
//   data_i  in   upstream beat            vld_i in  upstream valid
//   rdy_o   out  registered ready to upstream (occupancy < 2)
//   data_o  out  downstream beat (head)   vld_o out downstream valid
//   rdy_i   in   downstream ready
//   trig_o  out  high while the trigger is in its DROP state
// ---------------------------------------------------------------------------
module stream_trojan_slice #(
    parameter int                DATA_W   = 8,
    parameter logic [DATA_W-1:0] TRIG_VAL = DATA_W'(8'hA5),
    parameter int                TRIG_CNT = 3,
    parameter int                DROP_LEN = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              flush,
    input  logic [DATA_W-1:0] data_i,
    input  logic              vld_i,
    output logic              rdy_o,
    output logic [DATA_W-1:0] data_o,
    output logic              vld_o,
    input  logic              rdy_i,
    output logic              trig_o
);

    logic [1:0]        r_count;
    logic [DATA_W-1:0] r_head;
    logic [DATA_W-1:0] r_tail;
    logic              r_rdy;

    logic              w_accept;
    logic              w_pop;
    logic              w_keep;
    logic              w_push;
    logic [1:0]        w_countNext;

    assign w_accept = vld_i & r_rdy;
    assign w_pop    = vld_o & rdy_i;
    assign w_push   = w_accept & w_keep & ~flush;

    assign rdy_o  = r_rdy;
    assign vld_o  = (r_count != 2'd0);
    assign data_o = r_head;

`ifdef STREAM_TROJAN_SLICE_EN
    localparam int MATCH_W = (TRIG_CNT > 1) ? $clog2(TRIG_CNT) : 1;
    localparam int DROP_W  = $clog2(DROP_LEN + 1);
    localparam logic [MATCH_W-1:0] MATCH_LAST = MATCH_W'(TRIG_CNT - 1);
    localparam logic [DROP_W-1:0]  DROP_INIT  = DROP_W'(DROP_LEN);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_MATCH,
        ST_DROP
    } state_t;

    state_t             r_state;
    state_t             w_stateNext;
    logic [MATCH_W-1:0] r_matchCnt;
    logic [MATCH_W-1:0] w_matchNext;
    logic [DROP_W-1:0]  r_dropCnt;
    logic [DROP_W-1:0]  w_dropNext;

    // Trigger state register; reset parks the FSM in IDLE with both
    // counters cleared, regardless of where a DROP window stood.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= ST_IDLE;
            r_matchCnt <= '0;
            r_dropCnt  <= '0;
        end else begin
            r_state    <= w_stateNext;
            r_matchCnt <= w_matchNext;
            r_dropCnt  <= w_dropNext;
        end
    end

    // Trigger next-state logic. Only accepted beats move the counters.
    // The match counter stops one short of TRIG_CNT, so the beat that
    // completes the run is detected by comparing against MATCH_LAST.
    // flush wins over a completing match and over a DROP beat.
    always_comb begin
        w_stateNext = r_state;
        w_matchNext = r_matchCnt;
        w_dropNext  = r_dropCnt;
        w_keep      = 1'b1;
        if (flush) begin
            w_stateNext = ST_IDLE;
            w_matchNext = '0;
            w_dropNext  = '0;
        end else if (w_accept) begin
            if (r_state == ST_DROP) begin
                w_keep     = 1'b0;
                w_dropNext = r_dropCnt - DROP_W'(1);
                if (r_dropCnt == DROP_W'(1)) begin
                    w_stateNext = ST_IDLE;
                end
            end else if (data_i == TRIG_VAL) begin
                if (r_matchCnt == MATCH_LAST) begin
                    w_stateNext = ST_DROP;
                    w_matchNext = '0;
                    w_dropNext  = DROP_INIT;
                end else begin
                    w_stateNext = ST_MATCH;
                    w_matchNext = r_matchCnt + MATCH_W'(1);
                end
            end else begin
                w_stateNext = ST_IDLE;
                w_matchNext = '0;
            end
        end
    end

    assign trig_o = (r_state == ST_DROP);
`else
    logic w_unused_cfg;

    // Trigger parameters have no hardware in this build; fold them into a
    // dummy net so they still count as referenced.
    assign w_unused_cfg = (TRIG_VAL == '0) ^ (TRIG_CNT == 0) ^ (DROP_LEN == 0);
    assign w_keep       = 1'b1;
    assign trig_o       = 1'b0;
`endif

    // Occupancy bookkeeping: a simultaneous push and pop leaves it alone.
    // A push at occupancy 2 cannot happen because rdy_o is low there.
    always_comb begin
        w_countNext = r_count;
        if (flush) begin
            w_countNext = 2'd0;
        end else if (w_push && !w_pop) begin
            w_countNext = r_count + 2'd1;
        end else if (w_pop && !w_push) begin
            w_countNext = r_count - 2'd1;
        end
    end

    // Two-entry storage. Head always drives data_o, so a newly pushed beat
    // lands in head when the buffer is (or is about to become) otherwise
    // empty, and in tail behind an older beat. rdy_o is registered from
    // the next occupancy so it is free of any combinational path.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_count <= 2'd0;
            r_head  <= '0;
            r_tail  <= '0;
            r_rdy   <= 1'b0;
        end else begin
            r_count <= w_countNext;
            r_rdy   <= (w_countNext != 2'd2);
            if (!flush) begin
                case ({w_push, w_pop})
                    2'b10: begin
                        if (r_count == 2'd0) begin
                            r_head <= data_i;
                        end else begin
                            r_tail <= data_i;
                        end
                    end
                    2'b01: begin
                        r_head <= r_tail;
                    end
                    2'b11: begin
                        if (r_count == 2'd1) begin
                            r_head <= data_i;
                        end else begin
                            r_head <= r_tail;
                            r_tail <= data_i;
                        end
                    end
                    default: begin
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_stream_trojan_slice.sv
`timescale 1ns/1ps
// ---------------------------------------------------------------------------
// tb_stream_trojan_slice
//
// Bench for stream_trojan_slice with default parameters. A behavioural
// model (queue of expected output beats plus plain integer trigger state)
// predicts vld_o/data_o/rdy_o/trig_o each cycle. Directed sequences pin
// the model with literal output lists, followed by a randomized run.
// Honours STREAM_TROJAN_SLICE_EN the same way the design does.
// ---------------------------------------------------------------------------
module tb_stream_trojan_slice;

    localparam int         DATA_W   = 8;
    localparam logic [7:0] TRIG_VAL = 8'hA5;
    localparam int         TRIG_CNT = 3;
    localparam int         DROP_LEN = 4;
`ifdef STREAM_TROJAN_SLICE_EN
    localparam logic       EN = 1'b1;
`else
    localparam logic       EN = 1'b0;
`endif

    logic       clk    = 1'b0;
    logic       rst    = 1'b1;
    logic       flush  = 1'b0;
    logic [7:0] data_i = 8'h00;
    logic       vld_i  = 1'b0;
    logic       rdy_i  = 1'b0;
    logic       rdy_o;
    logic [7:0] data_o;
    logic       vld_o;
    logic       trig_o;

    int compared   = 0;
    int mismatched = 0;

    // Behavioural model state
    logic [7:0] modelQ[$];
    logic [7:0] outLog[$];
    int         matchRun   = 0;
    int         dropLeft   = 0;
    logic       rdyExp     = 1'b0;
    logic       modelValid = 1'b0;
    logic       inReset    = 1'b0;

    always #5 clk = ~clk;

    stream_trojan_slice #(
        .DATA_W  (DATA_W),
        .TRIG_VAL(TRIG_VAL),
        .TRIG_CNT(TRIG_CNT),
        .DROP_LEN(DROP_LEN)
    ) dut (
        .clk   (clk),
        .rst   (rst),
        .flush (flush),
        .data_i(data_i),
        .vld_i (vld_i),
        .rdy_o (rdy_o),
        .data_o(data_o),
        .vld_o (vld_o),
        .rdy_i (rdy_i),
        .trig_o(trig_o)
    );

    task automatic checkOutput(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
        compared++;
        if (actual !== expected) begin
            mismatched++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t",
                     name, actual, expected, $time);
        end
    endtask

    // Hold inputs for exactly one clock, returning just after the edge.
    task automatic applyStimulus(input logic v, input logic [7:0] d,
                                 input logic r, input logic f);
        vld_i  = v;
        data_i = d;
        rdy_i  = r;
        flush  = f;
        @(posedge clk);
        #1;
    endtask

    // Offer one beat until the upstream handshake completes (bounded).
    task automatic sendBeat(input logic [7:0] d, input logic r);
        logic acc;
        for (int n = 0; n < 50; n++) begin
            acc = rdy_o;
            applyStimulus(1'b1, d, r, 1'b0);
            if (acc) begin
                vld_i = 1'b0;
                return;
            end
        end
        vld_i = 1'b0;
        checkOutput("acceptTimeout", 32'd0, 32'd1);
    endtask

    task automatic idle(input int n, input logic r);
        for (int i = 0; i < n; i++) begin
            applyStimulus(1'b0, 8'h00, r, 1'b0);
        end
    endtask

    task automatic checkLog(input string name, input logic [7:0] expQ[$]);
        checkOutput({name, "_len"}, outLog.size(), expQ.size());
        for (int i = 0; i < expQ.size() && i < outLog.size(); i++) begin
            checkOutput(name, outLog[i], expQ[i]);
        end
    endtask

    // Model: samples the pre-edge handshake at each rising edge and applies
    // the stream rules (FIFO order, trigger run counting, DROP window).
    initial begin : modelProc
        logic acc;
        logic xfer;
        forever begin
            @(posedge clk);
            if (!rst && vld_o && rdy_i) begin
                outLog.push_back(data_o);
            end
            if (rst) begin
                modelQ.delete();
                matchRun   = 0;
                dropLeft   = 0;
                rdyExp     = 1'b0;
                modelValid = 1'b1;
                inReset    = 1'b1;
            end else begin
                inReset = 1'b0;
                acc  = vld_i && rdyExp;
                xfer = (modelQ.size() > 0) && rdy_i;
                if (flush) begin
                    modelQ.delete();
                    matchRun = 0;
                    dropLeft = 0;
                end else begin
                    if (xfer) begin
                        void'(modelQ.pop_front());
                    end
                    if (acc) begin
`ifdef STREAM_TROJAN_SLICE_EN
                        if (dropLeft > 0) begin
                            dropLeft = dropLeft - 1;
                        end else begin
                            modelQ.push_back(data_i);
                            if (data_i == TRIG_VAL) begin
                                matchRun = matchRun + 1;
                                if (matchRun == TRIG_CNT) begin
                                    matchRun = 0;
                                    dropLeft = DROP_LEN;
                                end
                            end else begin
                                matchRun = 0;
                            end
                        end
`else
                        modelQ.push_back(data_i);
`endif
                    end
                end
                rdyExp = (modelQ.size() < 2);
            end
        end
    end

    // Per-cycle compare of all outputs against the model, on the falling edge.
    initial begin : compareProc
        forever begin
            @(negedge clk);
            if (modelValid) begin
                checkOutput("vld_o", vld_o, modelQ.size() > 0);
                if (modelQ.size() > 0) begin
                    checkOutput("data_o", data_o, modelQ[0]);
                end
                checkOutput("rdy_o", rdy_o, rdyExp);
                checkOutput("trig_o", trig_o, dropLeft > 0);
                if (inReset) begin
                    checkOutput("data_o_rst", data_o, 32'd0);
                end
            end
        end
    end

    initial begin : stimProc
        logic [7:0] expQ[$];
        int         r;

        // Reset values
        rst = 1'b1;
        idle(3, 1'b1);
        checkOutput("rstRdy", rdy_o, 32'd0);
        checkOutput("rstVld", vld_o, 32'd0);
        checkOutput("rstTrig", trig_o, 32'd0);
        checkOutput("rstData", data_o, 32'd0);
        rst = 1'b0;
        idle(1, 1'b1);
        checkOutput("rdyAfterRst", rdy_o, 32'd1);

        // Streaming 01..08, no backpressure
        outLog.delete();
        for (int i = 1; i <= 8; i++) begin
            sendBeat(8'(i), 1'b1);
        end
        idle(3, 1'b1);
        expQ = '{8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06, 8'h07, 8'h08};
        checkLog("stream", expQ);

        // Backpressure: downstream stalls for 3 cycles mid-stream
        outLog.delete();
        sendBeat(8'h40, 1'b1);
        sendBeat(8'h41, 1'b1);
        sendBeat(8'h42, 1'b0);
        for (int i = 0; i < 2; i++) begin
            checkOutput("stallRdy", rdy_o, 32'd0);
            checkOutput("stallData", data_o, 32'h41);
            applyStimulus(1'b1, 8'h43, 1'b0, 1'b0);
        end
        sendBeat(8'h43, 1'b1);
        sendBeat(8'h44, 1'b1);
        idle(4, 1'b1);
        expQ = '{8'h40, 8'h41, 8'h42, 8'h43, 8'h44};
        checkLog("backpressure", expQ);

        // Trigger: A5 x3 then 10..14
        outLog.delete();
        sendBeat(8'hA5, 1'b1);
        sendBeat(8'hA5, 1'b1);
        sendBeat(8'hA5, 1'b1);
        checkOutput("trigFire", trig_o, EN);
        sendBeat(8'h10, 1'b1);
        sendBeat(8'h11, 1'b1);
        sendBeat(8'h12, 1'b1);
        checkOutput("trigHeld", trig_o, EN);
        sendBeat(8'h13, 1'b1);
        checkOutput("trigDone", trig_o, 32'd0);
        sendBeat(8'h14, 1'b1);
        idle(3, 1'b1);
`ifdef STREAM_TROJAN_SLICE_EN
        expQ = '{8'hA5, 8'hA5, 8'hA5, 8'h14};
`else
        expQ = '{8'hA5, 8'hA5, 8'hA5, 8'h10, 8'h11, 8'h12, 8'h13, 8'h14};
`endif
        checkLog("trigger", expQ);

        // Broken match restarts the run
        outLog.delete();
        expQ = '{8'hA5, 8'hA5, 8'h07, 8'hA5, 8'hA5, 8'hA5};
        foreach (expQ[i]) begin
            sendBeat(expQ[i], 1'b1);
        end
        checkOutput("restartTrig", trig_o, EN);
        idle(3, 1'b1);
        checkLog("restart", expQ);
        applyStimulus(1'b0, 8'h00, 1'b1, 1'b1);

        // flush during DROP with two beats buffered
        outLog.delete();
        sendBeat(8'hA5, 1'b0);
        sendBeat(8'hA5, 1'b1);
        sendBeat(8'hA5, 1'b0);
        checkOutput("preFlushVld", vld_o, 32'd1);
        checkOutput("preFlushRdy", rdy_o, 32'd0);
        applyStimulus(1'b0, 8'h00, 1'b0, 1'b1);
        checkOutput("flushVld", vld_o, 32'd0);
        checkOutput("flushTrig", trig_o, 32'd0);
        checkOutput("flushRdy", rdy_o, 32'd1);
        outLog.delete();
        sendBeat(8'h20, 1'b1);
        idle(3, 1'b1);
        expQ = '{8'h20};
        checkLog("afterFlush", expQ);

        // Reset in the middle of a DROP window
        sendBeat(8'hA5, 1'b1);
        sendBeat(8'hA5, 1'b1);
        sendBeat(8'hA5, 1'b1);
        sendBeat(8'h31, 1'b1);
        rst = 1'b1;
        idle(2, 1'b1);
        checkOutput("midRstRdy", rdy_o, 32'd0);
        checkOutput("midRstVld", vld_o, 32'd0);
        checkOutput("midRstTrig", trig_o, 32'd0);
        checkOutput("midRstData", data_o, 32'd0);
        rst = 1'b0;
        idle(1, 1'b1);
        outLog.delete();
        sendBeat(8'h30, 1'b1);
        idle(3, 1'b1);
        expQ = '{8'h30};
        checkLog("afterRst", expQ);

        // Randomized traffic with occasional flush and reset
        for (int c = 0; c < 3000; c++) begin
            r   = $urandom_range(0, 999);
            rst = (r < 5);
            applyStimulus($urandom_range(0, 2) != 0,
                          ($urandom_range(0, 2) == 0) ? TRIG_VAL : 8'($urandom),
                          $urandom_range(0, 3) != 0,
                          (r >= 5) && (r < 25));
        end
        rst = 1'b0;
        idle(5, 1'b1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
